// File: rtl/instr_loader.sv
// Program-load stage for the MIPS_Processor Main block.
// Assembles 16-bit instructions from a byte stream, high byte first. Each
// instruction is written into Main's instruction memory at the next address.
// The load ends on the end-of-program marker or when the memory is full.
// finish is then held so that Main can start.
module instr_loader #(
   parameter int          ADDR_W   = 8,
   parameter int          DATA_W   = 16,
   parameter logic [15:0] END_WORD = 16'hFFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              we,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] instruct_dir,
   output logic              finish,
   output logic              busy,
   output logic              full,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HIGH  = 3'd1,
      S_LOW   = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [7:0]          r_hi;
   logic [DATA_W-1:0]   r_instruction;
   logic [ADDR_W-1:0]   r_instruct_dir;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_word_count;
   logic                r_full;

   logic                w_byte_ready;
   logic                w_xfer;
   logic                w_is_end;
   logic                w_last;
   logic                w_we;
   logic                w_busy;
   logic                w_finish;

   // A byte moves only when the loader is asking for one.
   assign w_xfer   = byte_valid & w_byte_ready;
   // The assembled word is held in r_instruction during WRITE.
   assign w_is_end = (r_instruction == END_WORD);
   // r_instruct_dir holds the address being written in WRITE.
   assign w_last   = (r_instruct_dir == {ADDR_W{1'b1}});

   // State register. Reset aborts any load in progress at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and decoded handshake and status outputs.
   always_comb begin
      w_state_next = r_state;
      w_byte_ready = 1'b0;
      w_we         = 1'b0;
      w_busy       = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_HIGH;
            end
         end
         S_HIGH: begin
            w_byte_ready = 1'b1;
            w_busy       = 1'b1;
            if (w_xfer) begin
               w_state_next = S_LOW;
            end
         end
         S_LOW: begin
            w_byte_ready = 1'b1;
            w_busy       = 1'b1;
            if (w_xfer) begin
               w_state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            w_busy = 1'b1;
            if (w_is_end) begin
               w_state_next = S_DONE;
            end else begin
               w_we = 1'b1;
               // A write to the last address always ends the load.
               w_state_next = w_last ? S_DONE : S_HIGH;
            end
         end
         S_DONE: begin
            w_finish = 1'b1;
            if (start) begin
               w_state_next = S_HIGH;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: byte latching, write data and address, counters and full flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi           <= 8'd0;
         r_instruction  <= '0;
         r_instruct_dir <= '0;
         r_addr         <= '0;
         r_word_count   <= '0;
         r_full         <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_addr       <= '0;
                  r_word_count <= '0;
                  r_full       <= 1'b0;
               end
            end
            S_HIGH: begin
               if (w_xfer) begin
                  r_hi <= byte_in;
               end
            end
            S_LOW: begin
               if (w_xfer) begin
                  r_instruction  <= {r_hi, byte_in};
                  r_instruct_dir <= r_addr;
               end
            end
            S_WRITE: begin
               if (!w_is_end) begin
                  r_word_count <= r_word_count + (ADDR_W+1)'(1);
                  // The address is held at the top of memory; it never wraps.
                  if (w_last) begin
                     r_full <= 1'b1;
                  end else begin
                     r_addr <= r_addr + ADDR_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign byte_ready   = w_byte_ready;
   assign we           = w_we;
   assign busy         = w_busy;
   assign finish       = w_finish;
   assign instruction  = r_instruction;
   assign instruct_dir = r_instruct_dir;
   assign full         = r_full;
   assign word_count   = r_word_count;

endmodule
